// File: rtl/spinner_multi.sv
// rtl/spinner_multi.sv - multi-channel button/spinner angle accumulator with last-mover select
// Optional SPINNER_DELTA_EN adds per-channel rd / delta_out whole-unit movement counters.
module spinner_multi #(
    parameter int CHANNELS  = 2,
    parameter int OUT_W     = 4,
    parameter int FRAC      = 2,
    parameter int DIV_SLOW  = 8,
    parameter int STEP_FAST = 2,
    parameter int CLAMP     = 0,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fast,
    input  logic [CHANNELS-1:0]       minus,
    input  logic [CHANNELS-1:0]       plus,
    input  logic                      strobe,
    input  logic [CHANNELS*9-1:0]     spin_in,
`ifdef SPINNER_DELTA_EN
    input  logic [CHANNELS-1:0]       rd,
    output logic [CHANNELS*8-1:0]     delta_out,
`endif
    output logic [CHANNELS*OUT_W-1:0] spin_out,
    output logic [SEL_W-1:0]          sel,
    output logic [OUT_W-1:0]          spin_sel
);
    localparam int A  = OUT_W + FRAC;
    localparam int CW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
    // Sum is kept wide enough that acc + step + a full 8-bit delta never overflows before clamping.
    localparam int S  = A + 12;
    localparam logic signed [S-1:0] STEP_S  = S'(2 ** FRAC);
    localparam logic signed [S-1:0] STEP_F  = S'(STEP_FAST * (2 ** FRAC));
    localparam logic signed [S-1:0] SUM_MAX = S'((2 ** A) - 1);
    localparam logic [A-1:0]        ACC_MAX = A'((2 ** A) - (2 ** FRAC));
    localparam logic [CW-1:0]       CNT_TOP = CW'(DIV_SLOW - 1);

    logic [A-1:0]  acc_q [CHANNELS];
    logic [A-1:0]  acc_d [CHANNELS];
    logic [CW-1:0] cnt_q [CHANNELS];
    logic [CW-1:0] cnt_d [CHANNELS];
    logic [CHANNELS-1:0] tog_q;
    logic          strobe_q;
    logic          primed_q;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [OUT_W-1:0] spin_sel_q, spin_sel_d;
    logic          rise;

    always_comb begin
        logic signed [S-1:0] step;
        logic signed [S-1:0] spin;
        logic signed [S-1:0] sum;
        rise  = strobe & ~strobe_q;
        sel_d = sel_q;
        // Descending scan so the lowest moving channel is the last to claim sel.
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            step     = '0;
            spin     = '0;
            cnt_d[c] = cnt_q[c];
            if (rise) begin
                if (plus[c] ^ minus[c]) begin
                    if (fast) begin
                        step = STEP_F;
                    end else begin
                        if (cnt_q[c] == '0) step = STEP_S;
                        cnt_d[c] = (cnt_q[c] == CNT_TOP) ? '0 : cnt_q[c] + 1'b1;
                    end
                    if (minus[c]) step = -step;
                end else begin
                    cnt_d[c] = '0;
                end
            end
            if (primed_q && (spin_in[c*9+8] != tog_q[c]))
                spin = S'($signed(spin_in[c*9 +: 8]));
            sum = $signed({{(S-A){1'b0}}, acc_q[c]}) + step + spin;
            if (CLAMP != 0) begin
                if (sum < 0)            acc_d[c] = '0;
                else if (sum > SUM_MAX) acc_d[c] = ACC_MAX;
                else                    acc_d[c] = sum[A-1:0];
            end else begin
                acc_d[c] = sum[A-1:0];
            end
            if (acc_d[c] != acc_q[c]) sel_d = SEL_W'(c);
        end
        spin_sel_d = acc_d[sel_d][A-1:FRAC];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            primed_q   <= 1'b0;
            tog_q      <= '0;
            sel_q      <= '0;
            spin_sel_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            strobe_q   <= strobe;
            primed_q   <= 1'b1;
            sel_q      <= sel_d;
            spin_sel_q <= spin_sel_d;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= acc_d[c];
                cnt_q[c] <= cnt_d[c];
                tog_q[c] <= spin_in[c*9+8];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign spin_out[g*OUT_W +: OUT_W] = acc_q[g][A-1:FRAC];
    end
    assign sel      = sel_q;
    assign spin_sel = spin_sel_q;

`ifdef SPINNER_DELTA_EN
    localparam int DW = ((OUT_W + 1 > 8) ? OUT_W + 1 : 8) + 1;
    localparam logic signed [DW-1:0] D_MAX = DW'(127);
    localparam logic signed [DW-1:0] D_MIN = -DW'(128);

    logic [7:0] delta_q [CHANNELS];
    logic [7:0] delta_d [CHANNELS];

    always_comb begin
        logic [OUT_W:0]        dclamp;
        logic [OUT_W-1:0]      dwrap;
        logic signed [DW-1:0]  mv;
        logic signed [DW-1:0]  tot;
        for (int c = 0; c < CHANNELS; c++) begin
            dclamp = {1'b0, acc_d[c][A-1:FRAC]} - {1'b0, acc_q[c][A-1:FRAC]};
            dwrap  = acc_d[c][A-1:FRAC] - acc_q[c][A-1:FRAC];
            if (CLAMP != 0) mv = $signed(dclamp);
            else            mv = $signed(dwrap);
            tot = rd[c] ? mv : $signed(delta_q[c]) + mv;
            if (tot > D_MAX)      delta_d[c] = 8'd127;
            else if (tot < D_MIN) delta_d[c] = 8'h80;
            else                  delta_d[c] = tot[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) delta_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) delta_q[c] <= delta_d[c];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_delta
        assign delta_out[g*8 +: 8] = delta_q[g];
    end
`endif
endmodule

// File: tb/tb_spinner_multi.sv
// tb/tb_spinner_multi.sv - directed self-checking bench for spinner_multi (wrap and clamp builds)
module tb_spinner_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fast = 1'b0;
    logic [1:0]  minus = '0;
    logic [1:0]  plus = '0;
    logic        strobe = 1'b0;
    logic [17:0] spin_in;
    logic [7:0]  spin_out, spin_out_c;
    logic        sel, sel_c;
    logic [3:0]  spin_sel, spin_sel_c;
`ifdef SPINNER_DELTA_EN
    logic [1:0]  rd = '0;
    logic [15:0] delta_out, delta_out_c;
`endif
    logic        tog0 = 1'b1;
    logic        tog1 = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spinner_multi #(.CLAMP(0)) dut (
        .clk(clk), .reset(reset), .fast(fast), .minus(minus), .plus(plus),
        .strobe(strobe), .spin_in(spin_in),
`ifdef SPINNER_DELTA_EN
        .rd(rd), .delta_out(delta_out),
`endif
        .spin_out(spin_out), .sel(sel), .spin_sel(spin_sel)
    );

    spinner_multi #(.CLAMP(1)) dut_c (
        .clk(clk), .reset(reset), .fast(fast), .minus(minus), .plus(plus),
        .strobe(strobe), .spin_in(spin_in),
`ifdef SPINNER_DELTA_EN
        .rd(rd), .delta_out(delta_out_c),
`endif
        .spin_out(spin_out_c), .sel(sel_c), .spin_sel(spin_sel_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            tick();
        end
    endtask

    task automatic spin(input bit e0, input logic [7:0] d0, input bit e1, input logic [7:0] d1);
        if (e0) tog0 = ~tog0;
        if (e1) tog1 = ~tog1;
        spin_in = {tog1, d1, tog0, d0};
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        spin_in = {tog1, 8'd0, tog0, 8'd0};
        tick();
        check("reset_spin_out", spin_out, 0);
        check("reset_sel", sel, 0);
        check("reset_spin_sel", spin_sel, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("prime_spin_out", spin_out, 0);
        check("prime_sel", sel, 0);
        check("prime_spin_out_c", spin_out_c, 0);

        plus = 2'b01;
        pulses(1);
        check("slow_rise1", spin_out[3:0], 1);
        pulses(15);
        check("slow_rise16", spin_out[3:0], 2);
        minus = 2'b01;
        pulses(4);
        check("both_held", spin_out[3:0], 2);
        check("slow_spin_sel", spin_sel, 2);
        plus = '0;
        minus = '0;

        do_reset();
        fast = 1'b1;
        plus = 2'b01;
        pulses(3);
        check("fast_plus", spin_out[3:0], 6);
        check("fast_plus_c", spin_out_c[3:0], 6);
        plus = '0;
        minus = 2'b01;
        pulses(4);
        check("fast_minus_wrap", spin_out[3:0], 14);
        check("fast_minus_clamp", spin_out_c[3:0], 0);
        minus = '0;
        fast = 1'b0;

        spin(0, 8'd0, 1, 8'd6);
        check("ch1_delta6", spin_out[7:4], 1);
        spin(0, 8'd0, 1, 8'd2);
        check("ch1_delta2", spin_out[7:4], 2);
        check("ch1_sel", sel, 1);
        check("ch1_spin_sel", spin_sel, 2);
        check("ch0_hold", spin_out[3:0], 14);

        do_reset();
        spin(1, 8'hFD, 0, 8'd0);
        check("neg3_wrap", spin_out[3:0], 15);
        check("neg3_clamp", spin_out_c[3:0], 0);
        spin(1, 8'd127, 0, 8'd0);
        check("p127a_wrap", spin_out[3:0], 15);
        check("p127a_clamp", spin_out_c[3:0], 15);
        spin(1, 8'd127, 0, 8'd0);
        check("p127b_wrap", spin_out[3:0], 14);
        check("p127b_clamp", spin_out_c[3:0], 15);
        spin(0, 8'd0, 1, 8'd4);
        check("ch1_only_sel", sel, 1);
        spin(1, 8'd4, 1, 8'd4);
        check("both_sel", sel, 0);
        check("both_spin_sel", spin_sel, 15);
        check("both_sel_c", sel_c, 1);
        check("both_spin_sel_c", spin_sel_c, 2);

`ifdef SPINNER_DELTA_EN
        do_reset();
        spin(1, 8'd20, 0, 8'd0);
        check("delta_5", delta_out[7:0], 5);
        rd = 2'b01;
        tick();
        rd = '0;
        check("delta_clear", delta_out[7:0], 0);
        rd = 2'b01;
        spin(1, 8'd4, 0, 8'd0);
        rd = '0;
        check("delta_rd_move", delta_out[7:0], 1);
        tick();
        check("delta_hold", delta_out[7:0], 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
